hilo_seq_ctrl: RTL and testbench

- Sequencer for the multicycle HI/LO datapath of the CPU.
- Accepts MULT, DIV, MTHI and MTLO requests from the main control FSM.
- Latches operands and drives the start codes of the iterative divider and multiplier engines.
- Counts each engine's fixed latency, owns the architectural HI/LO registers, flags divide-by-zero, and supports flush on exception.

---
 rtl/hilo_pkg.sv | 24 ++
 rtl/hilo_seq_ctrl_if.sv | 40 ++++
 rtl/lat_counter.sv | 31 +++
 rtl/hilo_seq_ctrl.sv | 156 +++++++++++++++
 tb/tb_hilo_seq_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO sequencer: opcodes, engine start codes,
// FSM state encoding and the default engine latencies.
package hilo_pkg;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;

    localparam logic [1:0] ENG_CLR = 2'd0;
    localparam logic [1:0] ENG_RUN = 2'd1;

    // Run-cycle counts after which the engine hi/lo outputs are final.
    localparam int HILO_DIV_LAT  = 34;
    localparam int HILO_MULT_LAT = 33;
    localparam int HILO_CNT_W    = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WB   = 2'd2
    } hilo_state_e;

endpackage

// File: rtl/hilo_seq_ctrl_if.sv
// Request/response and engine-side signals of the HI/LO sequencer.
// slave is the sequencer's view; master is the control FSM plus engines.
interface hilo_seq_ctrl_if;

    logic        req;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;

    logic        busy;
    logic        done;
    logic        div0_exc;
    logic [31:0] hi;
    logic [31:0] lo;

    logic [31:0] eng_a;
    logic [31:0] eng_b;
    logic [1:0]  div_start;
    logic [1:0]  mult_start;
    logic [31:0] div_hi;
    logic [31:0] div_lo;
    logic [31:0] mult_hi;
    logic [31:0] mult_lo;

    modport master (
        output req, op, rs_val, rt_val, flush,
        output div_hi, div_lo, mult_hi, mult_lo,
        input  busy, done, div0_exc, hi, lo,
        input  eng_a, eng_b, div_start, mult_start
    );

    modport slave (
        input  req, op, rs_val, rt_val, flush,
        input  div_hi, div_lo, mult_hi, mult_lo,
        output busy, done, div0_exc, hi, lo,
        output eng_a, eng_b, div_start, mult_start
    );

endinterface

// File: rtl/lat_counter.sv
// Loadable down-counter timing an engine's fixed latency; last flags the
// final run cycle. Holds at zero once expired.
module lat_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             last
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - ONE;
        end
    end

    assign last = (count == ONE);

endmodule

// File: rtl/hilo_seq_ctrl.sv
// HI/LO sequencer: accepts MULT/DIV/MTHI/MTLO, runs the iterative engines for
// their fixed latency and owns the architectural HI/LO registers.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for req; MTHI/MTLO and divide-by-zero complete from here
// RUN   | selected engine running, latency counter decrementing
// WB    | engine outputs final; HI/LO written at the next edge
module hilo_seq_ctrl
    import hilo_pkg::*;
#(
    parameter int DIV_LAT  = HILO_DIV_LAT,
    parameter int MULT_LAT = HILO_MULT_LAT,
    parameter int CNT_W    = HILO_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    hilo_seq_ctrl_if.slave   bus
);

    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT);

    hilo_state_e      state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [31:0]      eng_a_q, eng_a_d;
    logic [31:0]      eng_b_q, eng_b_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic             done_q, done_d;
    logic             div0_q, div0_d;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_clear;
    logic             cnt_dec;
    logic             cnt_last;

    lat_counter #(.CNT_W(CNT_W)) u_lat_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .last     (cnt_last)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        eng_a_d      = eng_a_q;
        eng_b_d      = eng_b_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        done_d       = 1'b0;
        div0_d       = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_clear    = 1'b0;
        cnt_dec      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // flush in the same cycle drops the request entirely
                if (bus.req && !bus.flush) begin
                    case (bus.op)
                        OP_MTHI: begin
                            hi_d   = bus.rs_val;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = bus.rs_val;
                            done_d = 1'b1;
                        end
                        default: begin
                            if ((bus.op == OP_DIV) && (bus.rt_val == '0)) begin
                                done_d = 1'b1;
                                div0_d = 1'b1;
                            end else begin
                                state_d      = ST_RUN;
                                op_d         = bus.op;
                                eng_a_d      = bus.rs_val;
                                eng_b_d      = bus.rt_val;
                                cnt_load     = 1'b1;
                                cnt_load_val = (bus.op == OP_DIV) ? DIV_LOAD : MULT_LOAD;
                            end
                        end
                    endcase
                end
            end

            ST_RUN: begin
                if (bus.flush) begin
                    state_d   = ST_IDLE;
                    cnt_clear = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                    if (cnt_last) begin
                        state_d = ST_WB;
                    end
                end
            end

            ST_WB: begin
                state_d = ST_IDLE;
                if (bus.flush) begin
                    cnt_clear = 1'b1;
                end else begin
                    hi_d   = (op_q == OP_DIV) ? bus.div_hi : bus.mult_hi;
                    lo_d   = (op_q == OP_DIV) ? bus.div_lo : bus.mult_lo;
                    done_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_MULT;
            eng_a_q <= '0;
            eng_b_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            eng_a_q <= eng_a_d;
            eng_b_q <= eng_b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            div0_q  <= div0_d;
        end
    end

    // Start codes come straight from state, so the IDLE cycle between two
    // runs always presents a clear to the engine.
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.div_start  = ((state_q != ST_IDLE) && (op_q == OP_DIV))  ? ENG_RUN : ENG_CLR;
    assign bus.mult_start = ((state_q != ST_IDLE) && (op_q == OP_MULT)) ? ENG_RUN : ENG_CLR;
    assign bus.done       = done_q;
    assign bus.div0_exc   = div0_q;
    assign bus.hi         = hi_q;
    assign bus.lo         = lo_q;
    assign bus.eng_a      = eng_a_q;
    assign bus.eng_b      = eng_b_q;

endmodule

// File: tb/tb_hilo_seq_ctrl.sv
// Bench for hilo_seq_ctrl: behavioural engines, an operation-level reference
// model compared every cycle, directed scenarios and a randomized phase.
module tb_hilo_seq_ctrl;
    import hilo_pkg::*;

    localparam int DLAT = HILO_DIV_LAT;
    localparam int MLAT = HILO_MULT_LAT;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic chk_en = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   div_cycles = 0;

    hilo_seq_ctrl_if bus ();

    hilo_seq_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural engines: results only become valid after LAT run cycles.
    int          div_runs = 0;
    int          mult_runs = 0;
    logic [31:0] junk = 32'h0;
    logic signed [31:0] e_a, e_b;
    logic signed [63:0] e_wa, e_wb, e_p;
    logic [31:0] e_div_hi, e_div_lo, e_mult_hi, e_mult_lo;

    always @(posedge clk) begin
        div_runs  <= (bus.div_start == ENG_RUN)  ? div_runs + 1  : 0;
        mult_runs <= (bus.mult_start == ENG_RUN) ? mult_runs + 1 : 0;
    end

    always @(negedge clk) junk <= $urandom;

    always_comb begin
        e_a       = bus.eng_a;
        e_b       = bus.eng_b;
        e_wa      = e_a;
        e_wb      = e_b;
        e_p       = e_wa * e_wb;
        e_div_hi  = ~junk;
        e_div_lo  = junk;
        e_mult_hi = junk;
        e_mult_lo = ~junk;
        if (mult_runs >= MLAT) begin
            e_mult_hi = e_p[63:32];
            e_mult_lo = e_p[31:0];
        end
        if ((div_runs >= DLAT) && (e_b != 0)) begin
            e_div_lo = e_a / e_b;
            e_div_hi = e_a % e_b;
        end
    end

    assign bus.div_hi  = e_div_hi;
    assign bus.div_lo  = e_div_lo;
    assign bus.mult_hi = e_mult_hi;
    assign bus.mult_lo = e_mult_lo;

    // Reference model: m_left counts edges until the pending result lands.
    int          m_left = 0;
    logic [1:0]  m_op = OP_MULT;
    logic [31:0] m_hi = 0, m_lo = 0, m_ea = 0, m_eb = 0, m_rhi = 0, m_rlo = 0;
    logic        m_done = 0, m_div0 = 0;

    always @(posedge clk) begin : model
        logic signed [31:0] a32, b32;
        logic signed [63:0] sa, sb, p;
        m_done = 1'b0;
        m_div0 = 1'b0;
        if (reset) begin
            m_left = 0;
            m_op = OP_MULT;
            m_hi = 0; m_lo = 0; m_ea = 0; m_eb = 0;
        end else if (m_left > 0) begin
            if (bus.flush) begin
                m_left = 0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = m_rhi;
                    m_lo = m_rlo;
                    m_done = 1'b1;
                end
            end
        end else if (bus.req && !bus.flush) begin
            a32 = bus.rs_val;
            b32 = bus.rt_val;
            case (bus.op)
                OP_MTHI: begin m_hi = bus.rs_val; m_done = 1'b1; end
                OP_MTLO: begin m_lo = bus.rs_val; m_done = 1'b1; end
                OP_DIV: begin
                    if (b32 == 0) begin
                        m_done = 1'b1;
                        m_div0 = 1'b1;
                    end else begin
                        m_op = OP_DIV; m_ea = bus.rs_val; m_eb = bus.rt_val;
                        m_rlo = a32 / b32;
                        m_rhi = a32 % b32;
                        m_left = DLAT + 1;
                    end
                end
                default: begin
                    sa = a32; sb = b32; p = sa * sb;
                    m_op = OP_MULT; m_ea = bus.rs_val; m_eb = bus.rt_val;
                    m_rhi = p[63:32];
                    m_rlo = p[31:0];
                    m_left = MLAT + 1;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",       32'(bus.busy),       32'(m_left > 0));
            check("done",       32'(bus.done),       32'(m_done));
            check("div0_exc",   32'(bus.div0_exc),   32'(m_div0));
            check("hi",         bus.hi,              m_hi);
            check("lo",         bus.lo,              m_lo);
            check("eng_a",      bus.eng_a,           m_ea);
            check("eng_b",      bus.eng_b,           m_eb);
            check("div_start",  32'(bus.div_start),  32'((m_left > 0 && m_op == OP_DIV)  ? 1 : 0));
            check("mult_start", 32'(bus.mult_start), 32'((m_left > 0 && m_op == OP_MULT) ? 1 : 0));
        end
    end

    always @(negedge clk) if (bus.div_start == ENG_RUN) div_cycles++;

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        bus.req = 1'b1; bus.op = o; bus.rs_val = a; bus.rt_val = b;
        @(negedge clk);
        bus.req = 1'b0; bus.op = 2'($urandom); bus.rs_val = $urandom; bus.rt_val = $urandom;
    endtask

    task automatic wait_idle(input string tag);
        int g = 0;
        while (bus.busy === 1'b1 && g < 200) begin
            @(negedge clk);
            g++;
        end
        check({tag, "_timeout"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [31:0] rs, rt;
        bus.req = 1'b0; bus.op = OP_MULT; bus.rs_val = 0; bus.rt_val = 0; bus.flush = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_hi", bus.hi, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_div_start", 32'(bus.div_start), 32'd0);
        reset = 1'b0;

        div_cycles = 0;
        issue(OP_DIV, 32'd100, 32'd7);
        wait_idle("div1");
        check("div1_lo", bus.lo, 32'd14);
        check("div1_hi", bus.hi, 32'd2);
        check("div1_done", 32'(bus.done), 32'd1);
        check("div1_start_cycles", 32'(div_cycles), 32'd35);
        check("model_div1_lo", m_lo, 32'd14);

        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle("div2");
        check("div2_lo", bus.lo, 32'hFFFF_FFFD);
        check("div2_hi", bus.hi, 32'hFFFF_FFFF);

        issue(OP_MTHI, 32'h1234, 32'd0);
        issue(OP_MTLO, 32'h5678, 32'd0);
        div_cycles = 0;
        issue(OP_DIV, 32'h55, 32'd0);
        check("div0_done", 32'(bus.done), 32'd1);
        check("div0_exc", 32'(bus.div0_exc), 32'd1);
        check("div0_busy", 32'(bus.busy), 32'd0);
        check("div0_hi", bus.hi, 32'h1234);
        check("div0_lo", bus.lo, 32'h5678);
        @(negedge clk);
        check("div0_exc_after", 32'(bus.div0_exc), 32'd0);
        check("div0_start_cycles", 32'(div_cycles), 32'd0);

        issue(OP_MULT, 32'h0001_0000, 32'h0001_0000);
        wait_idle("mult1");
        check("mult1_hi", bus.hi, 32'd1);
        check("mult1_lo", bus.lo, 32'd0);
        check("mult1_done", 32'(bus.done), 32'd1);
        check("b2b_clear", 32'(bus.div_start), 32'd0);
        issue(OP_DIV, 32'd100, 32'd7);
        check("b2b_run", 32'(bus.div_start), 32'd1);
        wait_idle("b2b");

        issue(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
        check("mthi_hi", bus.hi, 32'hDEAD_BEEF);
        check("mthi_busy", 32'(bus.busy), 32'd0);
        issue(OP_MTLO, 32'hCAFE_F00D, 32'd0);
        check("mtlo_lo", bus.lo, 32'hCAFE_F00D);
        check("mtlo_done", 32'(bus.done), 32'd1);

        issue(OP_DIV, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy", 32'(bus.busy), 32'd0);
        repeat (40) @(negedge clk);
        check("flush_hi", bus.hi, 32'hDEAD_BEEF);
        check("flush_lo", bus.lo, 32'hCAFE_F00D);

        bus.flush = 1'b1;
        issue(OP_MTHI, 32'h1, 32'd0);
        bus.flush = 1'b0;
        check("flush_req_done", 32'(bus.done), 32'd0);
        check("flush_req_hi", bus.hi, 32'hDEAD_BEEF);

        issue(OP_DIV, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_hi", bus.hi, 32'd0);
        check("rst_mid_lo", bus.lo, 32'd0);
        check("rst_mid_busy", 32'(bus.busy), 32'd0);
        check("rst_mid_eng_a", bus.eng_a, 32'd0);

        repeat (4000) begin
            rs = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 200)) : $urandom;
            case ($urandom_range(0, 7))
                0:       rt = 32'd0;
                1:       rt = 32'($urandom_range(1, 9));
                default: rt = $urandom;
            endcase
            if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) rt = 32'd1;
            bus.req    = ($urandom_range(0, 3) != 0);
            bus.op     = 2'($urandom);
            bus.rs_val = rs;
            bus.rt_val = rt;
            bus.flush  = ($urandom_range(0, 99) == 0);
            reset      = ($urandom_range(0, 499) == 0);
            @(negedge clk);
        end
        bus.req = 1'b0; bus.flush = 1'b0; reset = 1'b0;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
